// File: rtl/simple_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package simple_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Which requester currently owns the memory port (IDLE means nobody).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable 3-bit down-counter that times one fixed-latency memory access.
// first_o marks the cycle right after a load, done_o the cycle the data is valid.
module mem_lat_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic       first_o,
  output logic       done_o
);

  logic [2:0] cnt_q, cnt_d;

  // Next count: reload on a grant, otherwise count down and park at zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign first_o = (cnt_q == load_val_i);
  assign done_o  = (cnt_q == 3'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One access at a time, MEM stage preferred, IF protected from starvation.
module mem_port_arbiter
  import simple_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  logic [2:0]        starve_q, starve_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic lat_load, lat_first, lat_done;
  logic grant_if, grant_dm;
  logic drop_now;

  mem_lat_counter u_lat (
    .clock      (clock),
    .reset      (reset),
    .load_i     (lat_load),
    .load_val_i (LAT_LOAD),
    .first_o    (lat_first),
    .done_o     (lat_done)
  );

  // Grant decision, request latching, starvation tracking and abort bookkeeping.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    lat_load = 1'b0;
    grant_if = 1'b0;
    grant_dm = 1'b0;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!halt) begin
          if (if_req && (!dm_req || starve_q == STARVE_MAX)) begin
            grant_if = 1'b1;
          end else if (dm_req) begin
            grant_dm = 1'b1;
          end
        end
        if (grant_if) begin
          state_d  = BUSY_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          lat_load = 1'b1;
          starve_d = 3'd0;
        end else if (grant_dm) begin
          state_d  = BUSY_DM;
          addr_d   = dm_addr;
          we_d     = dm_we;
          wdata_d  = dm_wdata;
          lat_load = 1'b1;
          if (if_req && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 3'd1;
          end
        end
        if (!if_req) begin
          starve_d = 3'd0;
        end
      end
      BUSY_IF: begin
        if (lat_done) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else begin
          drop_d = drop_q | if_abort;
        end
      end
      BUSY_DM: begin
        if (lat_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state and latched access registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= 3'd0;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  // An abort raised in the completion cycle must already hide that cycle's ready.
  assign drop_now = drop_q | if_abort;

  assign mem_en    = (state_q != IDLE) && lat_first;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign if_ready = (state_q == BUSY_IF) && lat_done && !drop_now;
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign dm_ready = (state_q == BUSY_DM) && lat_done;
  assign dm_rdata = (dm_ready && !we_q) ? mem_rdata : '0;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule
